lcv_div_iter: RTL and testbench
===============================

// Module: lcv_div_iter
// PURPOSE
//  Iterative radix-2 restoring integer divider; the inverse companion of the
//  multiply-accumulate units. Produces quotient and remainder, signed or
//  unsigned per operation, one quotient bit per clock. Sits beside the ALU
//  as a multi-cycle functional unit with valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (>= 4)
// PORTS
//  clk               in   1      clock, all state on rising edge
//  rst               in   1      asynchronous, active-high reset
//  inp_valid         in   1      request valid
//  inp_ready         out  1      request accepted when inp_valid && inp_ready
//  inp_a             in   WIDTH  dividend
//  inp_b             in   WIDTH  divisor
//  inp_signed        in   1      1: two's-complement operands; 0: unsigned
//  outp_valid        out  1      result valid
//  outp_ready        in   1      result consumed when outp_valid && outp_ready
//  outp_quot         out  WIDTH  quotient
//  outp_rem          out  WIDTH  remainder
//  outp_div_by_zero  out  1      inp_b was zero
// BEHAVIOUR
//  - Reset: state IDLE; outp_valid=0, outp_quot=0, outp_rem=0,
//    outp_div_by_zero=0; iteration counter=0. Reset in any state aborts the
//    operation; no result is emitted for it.
//  - inp_ready = (state == IDLE), registered-state decode, no comb path
//    from outp_ready. No accept while busy or while a result is held.
//  - FSM: IDLE -accept-> PREP -> RUN (WIDTH cycles) -> FIXUP -> DONE
//    -outp_ready-> IDLE. DONE with outp_ready low stays in DONE.
//  - Latency fixed: accept at edge T, outp_valid rises at edge T+WIDTH+3
//    for every operand value, including divide-by-zero.
//  - PREP: latch signs; take magnitudes when inp_signed (|MIN| held in
//    WIDTH+1 bits); record div_by_zero = (inp_b == 0).
//  - RUN: partial remainder WIDTH+1 bits; each cycle shift in next dividend
//    MSB, trial-subtract divisor, keep if non-negative, quotient bit = !borrow.
//    Counter counts WIDTH down to 0; exit RUN on last bit.
//  - FIXUP (signed): quotient negated iff dividend and divisor signs differ
//    (truncation toward zero); remainder takes dividend's sign.
//  - Special cases (override FIXUP, both modes):
//    divide by zero: quot = all ones, rem = inp_a, div_by_zero = 1.
//    signed overflow MIN / -1: quot = MIN, rem = 0, div_by_zero = 0.
//  - DONE: outp_valid=1; outp_quot/outp_rem/outp_div_by_zero stable until
//    the handshake cycle. On handshake, outp_valid=0 next cycle; data
//    outputs hold last value (not cleared).
//  - Operands are captured at accept; later inp_* changes have no effect.
// TESTING
//  1 unsigned 100/7, accept at T -> q=14, r=2, dbz=0, outp_valid at T+35.
//  2 signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=-3, r=1.
//  3 5/0 (either mode) -> q=0xFFFFFFFF, r=5, dbz=1, same latency T+35.
//  4 signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned
//    0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  5 outp_ready low 10 cycles after valid -> outputs stable, inp_ready=0;
//    raise outp_ready -> outp_valid=0, inp_ready=1 next cycle.
//  6 assert rst at T+10 mid-RUN -> outp_valid=0, inp_ready=1 immediately;
//    next op 9/3 -> q=3, r=0 at its own accept+35.

Source files
------------

// File: rtl/lcv_div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Signed or unsigned per operation, valid/ready handshake on both sides.
module lcv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem,
  output logic             outp_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q, a_neg_q, b_neg_q, dbz_q;
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             outp_valid_q, outp_dbz_q;
  logic [WIDTH-1:0] outp_quot_q, outp_rem_q;

  logic             a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             overflow;
  logic [WIDTH-1:0] quot_d, rem_out_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_neg_d   = signed_q & a_q[WIDTH-1];
    b_neg_d   = signed_q & b_q[WIDTH-1];
    // |MIN| wraps to MIN, which is the correct unsigned magnitude
    a_mag_d   = a_neg_d ? -a_q : a_q;
    b_mag_d   = b_neg_d ? -b_q : b_q;

    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {1'b0, dsr_q};
    borrow    = trial[WIDTH+1];
    rem_d     = borrow ? rem_shift : trial[WIDTH:0];
    dvd_d     = {dvd_q[WIDTH-2:0], ~borrow};

    overflow  = signed_q && (a_q == MIN_VAL) && (b_q == '1);
    quot_d    = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
    rem_out_d = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (dbz_q) begin
      quot_d    = '1;
      rem_out_d = a_q;
    end else if (overflow) begin
      quot_d    = MIN_VAL;
      rem_out_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      signed_q     <= 1'b0;
      a_neg_q      <= 1'b0;
      b_neg_q      <= 1'b0;
      dbz_q        <= 1'b0;
      dvd_q        <= '0;
      rem_q        <= '0;
      dsr_q        <= '0;
      cnt_q        <= '0;
      outp_valid_q <= 1'b0;
      outp_dbz_q   <= 1'b0;
      outp_quot_q  <= '0;
      outp_rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inp_valid) begin
            a_q      <= inp_a;
            b_q      <= inp_b;
            signed_q <= inp_signed;
            state_q  <= S_PREP;
          end
        end
        S_PREP: begin
          a_neg_q <= a_neg_d;
          b_neg_q <= b_neg_d;
          dbz_q   <= (b_q == '0);
          dvd_q   <= a_mag_d;
          rem_q   <= '0;
          dsr_q   <= {1'b0, b_mag_d};
          cnt_q   <= CW'(WIDTH);
          state_q <= S_RUN;
        end
        S_RUN: begin
          // counter walks WIDTH..0; the zero cycle only hands over to FIXUP
          if (cnt_q != '0) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          outp_quot_q  <= quot_d;
          outp_rem_q   <= rem_out_d;
          outp_dbz_q   <= dbz_q;
          outp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (outp_ready) begin
            outp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inp_ready        = (state_q == S_IDLE);
  assign outp_valid       = outp_valid_q;
  assign outp_quot        = outp_quot_q;
  assign outp_rem         = outp_rem_q;
  assign outp_div_by_zero = outp_dbz_q;

endmodule

// File: tb/tb_lcv_div_iter.sv
// Self-checking bench for lcv_div_iter: directed corner cases, reset abort,
// output back-pressure, and random operands against an arithmetic reference.
module tb_lcv_div_iter;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_valid;
  logic         inp_ready;
  logic [W-1:0] inp_a, inp_b;
  logic         inp_signed;
  logic         outp_valid;
  logic         outp_ready;
  logic [W-1:0] outp_quot, outp_rem;
  logic         outp_div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  lcv_div_iter #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .inp_valid        (inp_valid),
    .inp_ready        (inp_ready),
    .inp_a            (inp_a),
    .inp_b            (inp_b),
    .inp_signed       (inp_signed),
    .outp_valid       (outp_valid),
    .outp_ready       (outp_ready),
    .outp_quot        (outp_quot),
    .outp_rem         (outp_rem),
    .outp_div_by_zero (outp_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dbz);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int waited = 0;
    @(negedge clk);
    while (!inp_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".ready_wait"}, inp_ready, 1);
    inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
    @(posedge clk);
    #1;
    inp_valid  = 1'b0;
    inp_a      = $urandom;
    inp_b      = $urandom;
    inp_signed = ~s;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (outp_valid) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input int hold,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat;
    issue(tag, a, b, s);
    wait_valid(lat);
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".quot"}, outp_quot, eq);
    chk({tag, ".rem"}, outp_rem, er);
    chk({tag, ".dbz"}, outp_div_by_zero, edbz);
    chk({tag, ".busy"}, inp_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, outp_valid, 1);
      chk({tag, ".hold_data"}, {outp_quot, outp_rem}, {eq, er});
      chk({tag, ".hold_busy"}, inp_ready, 0);
    end
    @(negedge clk);
    outp_ready = 1'b1;
    @(posedge clk);
    #1;
    outp_ready = 1'b0;
    chk({tag, ".drop_valid"}, outp_valid, 0);
    chk({tag, ".ready_again"}, inp_ready, 1);
    chk({tag, ".data_kept"}, {outp_quot, outp_rem}, {eq, er});
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         md;
    bit           rs;
    int           seen;

    rst = 1'b1; inp_valid = 1'b0; inp_a = '0; inp_b = '0; inp_signed = 1'b0; outp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", outp_valid, 0);
    chk("reset.quot", outp_quot, 0);
    chk("reset.rem", outp_rem, 0);
    chk("reset.dbz", outp_div_by_zero, 0);
    chk("reset.ready", inp_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    run_op("u100_7",    32'd100,        32'd7,          1'b0, 0, 32'd14,       32'd2,        1'b0);
    run_op("s-7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s7_-2",     32'd7,          32'hFFFF_FFFE,  1'b1, 0, 32'hFFFF_FFFD, 32'd1,        1'b0);
    run_op("u5_0",      32'd5,          32'd0,          1'b0, 0, 32'hFFFF_FFFF, 32'd5,        1'b1);
    run_op("s5_0",      32'd5,          32'd0,          1'b1, 0, 32'hFFFF_FFFF, 32'd5,        1'b1);
    run_op("smin_-1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0, 32'h8000_0000, 32'd0,        1'b0);
    run_op("umax_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 0, 32'hFFFF_FFFF, 32'd0,        1'b0);
    run_op("stall10",   32'd1000,       32'd33,         1'b0, 10, 32'd30,      32'd10,       1'b0);

    // Reset in the middle of RUN aborts the operation without a result.
    issue("abort", 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.valid", outp_valid, 0);
    chk("abort.ready", inp_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk);
      #1;
      if (outp_valid) seen++;
    end
    chk("abort.no_result", seen, 0);
    run_op("after_abort", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 6)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 15);
        2: rb = '0;
        3: rb = '1;
        4: rb = $urandom >> $urandom_range(0, 31);
        default: rb = -($urandom_range(1, 200));
      endcase
      if (i % 8 == 3) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, mq, mr, md);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, $urandom_range(0, 2), mq, mr, md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
